// File: rtl/keyboard_event_decoder.sv
// PS/2 key-event decoder: scan-byte intake, E0/E1/F0 prefix decode, held-key table
// with typematic repeat handling, and a first-word-fall-through event FIFO.
module keyboard_event_decoder #(
    parameter int unsigned NKEYS     = 6,
    parameter int unsigned FIFO_AW   = 3,
    parameter int unsigned HC_W      = 3,
    parameter bit          REPEAT_EN = 1'b0
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            scan_ready,
    input  logic [7:0]      scan_code,
    output logic            read,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic            ev_make,
    output logic            ev_ext,
    output logic            ev_repeat,
    output logic [7:0]      ev_code,
    output logic [HC_W-1:0] held_count,
    output logic            overflow,
    input  logic            clear_overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned IW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;

    typedef enum logic [1:0] {StIdle, StAck, StWaitLo} state_e;

    state_e          state_q;
    logic [7:0]      byte_q;
    logic            ext_q, brk_q;
    logic [2:0]      skip_q;
    logic [NKEYS-1:0] slot_vld_q;
    logic [8:0]      slot_key_q [NKEYS];
    logic [HC_W-1:0] held_q;
    logic [10:0]     mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;

    logic            ext_d, brk_d;
    logic [2:0]      skip_d;
    logic [8:0]      key;
    logic            hit, has_free, ins, clr, ignored;
    logic [IW-1:0]   hit_idx, free_idx;
    logic            push, push_ok, pop, full;
    logic [10:0]     push_data;   // {make, ext, repeat, code}

    // Intake handshake: read is a registered one-cycle acknowledge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            byte_q  <= '0;
            read    <= 1'b0;
        end else begin
            read <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (scan_ready) begin
                        byte_q  <= scan_code;
                        read    <= 1'b1;
                        state_q <= StAck;
                    end
                end
                StAck:    state_q <= StWaitLo;
                StWaitLo: if (!scan_ready) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Parallel lookup of the 9-bit key and the lowest free slot.
    always_comb begin
        key      = {ext_q, byte_q};
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < int'(NKEYS); i++) begin
            if (!hit && slot_vld_q[i] && slot_key_q[i] == key) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!has_free && !slot_vld_q[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign ignored = byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        ins       = 1'b0;
        clr       = 1'b0;
        if (state_q == StAck) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (byte_q == 8'hE1) begin
                skip_d    = 3'd7;
                push      = 1'b1;
                push_data = {1'b1, 1'b0, 1'b0, 8'hE1};
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ignored) begin
                    if (brk_q) begin
                        clr       = hit;
                        push      = 1'b1;
                        push_data = {1'b0, ext_q, 1'b0, byte_q};
                    end else if (hit) begin
                        push      = REPEAT_EN;
                        push_data = {1'b1, ext_q, 1'b1, byte_q};
                    end else begin
                        // A full table still reports the make; the key just goes untracked.
                        ins       = has_free;
                        push      = 1'b1;
                        push_data = {1'b1, ext_q, 1'b0, byte_q};
                    end
                end
            end
        end
    end

    assign full     = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    assign ev_valid = (cnt_q != '0);
    assign pop      = ev_valid && ev_ready;
    assign push_ok  = push && (!full || pop);

    assign {ev_make, ev_ext, ev_repeat, ev_code} = ev_valid ? mem_q[rd_ptr_q] : 11'd0;
    assign held_count = held_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            slot_vld_q <= '0;
            held_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < int'(NKEYS); i++) slot_key_q[i] <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
            if (ins) begin
                slot_vld_q[free_idx] <= 1'b1;
                slot_key_q[free_idx] <= key;
                held_q               <= held_q + HC_W'(1);
            end
            if (clr) begin
                slot_vld_q[hit_idx] <= 1'b0;
                held_q              <= held_q - HC_W'(1);
            end
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            else if (clear_overflow)  overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keyboard_event_decoder.sv
// Directed bench for keyboard_event_decoder; a second instance runs with REPEAT_EN=1.
module tb_keyboard_event_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       resetn, scan_ready, ev_ready, clear_overflow;
    logic [7:0] scan_code;

    logic       read, ev_valid, ev_make, ev_ext, ev_repeat, overflow;
    logic [7:0] ev_code;
    logic [2:0] held_count;
    logic       read_r, ev_valid_r, ev_make_r, ev_ext_r, ev_repeat_r, overflow_r;
    logic [7:0] ev_code_r;
    logic [2:0] held_count_r;

    int checks = 0;
    int failures = 0;
    int n;
    logic [7:0] last;

    always #10 CLOCK_50 = ~CLOCK_50;

    keyboard_event_decoder #(.NKEYS(6), .FIFO_AW(3), .HC_W(3), .REPEAT_EN(1'b0)) u_dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .scan_ready(scan_ready), .scan_code(scan_code),
        .read(read), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_make(ev_make),
        .ev_ext(ev_ext), .ev_repeat(ev_repeat), .ev_code(ev_code), .held_count(held_count),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    keyboard_event_decoder #(.NKEYS(6), .FIFO_AW(3), .HC_W(3), .REPEAT_EN(1'b1)) u_dut_rep (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .scan_ready(scan_ready), .scan_code(scan_code),
        .read(read_r), .ev_valid(ev_valid_r), .ev_ready(ev_ready), .ev_make(ev_make_r),
        .ev_ext(ev_ext_r), .ev_repeat(ev_repeat_r), .ev_code(ev_code_r),
        .held_count(held_count_r), .overflow(overflow_r), .clear_overflow(clear_overflow)
    );

    // {valid, make, ext, repeat, code}
    wire [11:0] head   = {ev_valid, ev_make, ev_ext, ev_repeat, ev_code};
    wire [11:0] head_r = {ev_valid_r, ev_make_r, ev_ext_r, ev_repeat_r, ev_code_r};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_on_ack);
        bit got = 1'b0;
        @(posedge CLOCK_50); #1;
        scan_code  = b;
        scan_ready = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge CLOCK_50); #1;
            if (read) got = 1'b1;
        end
        if (!got) check_eq("read_timeout", 0, 1);
        if (pop_on_ack) ev_ready = 1'b1;
        scan_ready = 1'b0;
        @(posedge CLOCK_50); #1;
        ev_ready = 1'b0;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic pop1();
        ev_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        ev_ready = 1'b0;
    endtask

    task automatic drain(output int cnt, output logic [7:0] lst);
        cnt = 0;
        lst = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (ev_valid) begin
                cnt++;
                lst = ev_code;
            end
            ev_ready = 1'b1;
            @(posedge CLOCK_50); #1;
        end
        ev_ready = 1'b0;
    endtask

    logic [7:0] pause_seq [8];

    initial begin
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        resetn = 1'b0; scan_ready = 1'b0; scan_code = 8'h00;
        ev_ready = 1'b0; clear_overflow = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("rst_read", read, 0);
        check_eq("rst_head", head, 0);
        check_eq("rst_held", held_count, 0);
        check_eq("rst_ovf", overflow, 0);
        resetn = 1'b1;
        @(posedge CLOCK_50); #1;

        // Latency: present at t, read at t+1, ev_valid at t+2.
        scan_code = 8'h1C; scan_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        check_eq("t1_read_hi", {read, read_r}, 2'b11);
        check_eq("t1_valid_early", ev_valid, 0);
        @(posedge CLOCK_50); #1;
        check_eq("t1_read_one_cycle", read, 0);
        check_eq("t1_head", head, 12'hC1C);
        check_eq("t1_held", held_count, 1);
        scan_ready = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;

        // Typematic repeats.
        send_byte(8'h1C, 0);
        send_byte(8'h1C, 0);
        check_eq("rep0_head", head, 12'hC1C);
        check_eq("rep1_head0", head_r, 12'hC1C);
        pop1();
        check_eq("rep0_single", head, 12'h000);
        check_eq("rep1_head1", head_r, 12'hD1C);
        pop1();
        check_eq("rep1_head2", head_r, 12'hD1C);
        pop1();
        check_eq("rep1_empty", head_r, 12'h000);
        check_eq("rep_held", {held_count, held_count_r}, {3'd1, 3'd1});
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        check_eq("brk_1c", head, 12'h81C);
        check_eq("brk_1c_held", held_count, 0);
        pop1();

        // Extended keys are distinct from plain ones.
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        check_eq("ext_make", head, 12'hE75);
        check_eq("ext_make_held", held_count, 1);
        pop1();
        send_byte(8'h75, 0);
        check_eq("plain_make", head, 12'hC75);
        check_eq("plain_make_held", held_count, 2);
        pop1();
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
        check_eq("ext_brk", head, 12'hA75);
        check_eq("ext_brk_held", held_count, 1);
        pop1();
        send_byte(8'hF0, 0); send_byte(8'h75, 0);
        check_eq("plain_brk", head, 12'h875);
        check_eq("plain_brk_held", held_count, 0);
        pop1();

        // Table saturation.
        for (int k = 1; k <= 7; k++) send_byte(8'(k), 0);
        drain(n, last);
        check_eq("sat_events", n, 7);
        check_eq("sat_last", last, 8'h07);
        check_eq("sat_held", held_count, 6);
        send_byte(8'hF0, 0); send_byte(8'h07, 0);
        check_eq("sat_brk7", head, 12'h807);
        check_eq("sat_brk7_held", held_count, 6);
        pop1();
        for (int k = 1; k <= 6; k++) begin
            send_byte(8'hF0, 0);
            send_byte(8'(k), 0);
        end
        drain(n, last);
        check_eq("sat_rel_events", n, 6);
        check_eq("sat_rel_held", held_count, 0);

        // FIFO overflow and push-while-full with a simultaneous pop.
        for (int k = 0; k < 9; k++) send_byte(8'h10 + 8'(k), 0);
        check_eq("ovf_set", {overflow, overflow_r}, 2'b11);
        check_eq("ovf_head", head, 12'hC10);
        clear_overflow = 1'b1;
        @(posedge CLOCK_50); #1;
        clear_overflow = 1'b0;
        check_eq("ovf_clear", overflow, 0);
        send_byte(8'h19, 1);
        check_eq("full_pushpop_ovf", overflow, 0);
        check_eq("full_pushpop_head", head, 12'hC11);
        drain(n, last);
        check_eq("full_pushpop_cnt", n, 8);
        check_eq("full_pushpop_last", last, 8'h19);
        for (int k = 0; k < 6; k++) begin
            send_byte(8'hF0, 0);
            send_byte(8'h10 + 8'(k), 0);
        end
        drain(n, last);
        check_eq("ovf_rel_events", n, 6);
        check_eq("ovf_rel_held", held_count, 0);

        // Pause sequence yields one event, then normal decode resumes.
        for (int k = 0; k < 8; k++) send_byte(pause_seq[k], 0);
        drain(n, last);
        check_eq("pause_cnt", n, 1);
        check_eq("pause_code", last, 8'hE1);
        send_byte(8'h1C, 0);
        check_eq("post_pause", head, 12'hC1C);
        pop1();

        // Asynchronous reset mid-pause: 1C already held, E1 event queued.
        send_byte(8'hE1, 0);
        send_byte(8'h14, 0);
        resetn = 1'b0;
        #1;
        check_eq("arst_head", head, 12'h000);
        check_eq("arst_misc", {read, held_count, overflow}, 5'b0);
        @(posedge CLOCK_50); #5;
        resetn = 1'b1;
        send_byte(8'h1C, 0);
        check_eq("arst_next", head, 12'hC1C);
        check_eq("arst_next_held", held_count, 1);
        drain(n, last);
        check_eq("arst_next_cnt", n, 1);

        // Ignored bytes cancel a pending E0 prefix.
        send_byte(8'hE0, 0); send_byte(8'hAA, 0); send_byte(8'h23, 0);
        check_eq("ignored_clears_ext", head, 12'hC23);
        pop1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
